// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared raster timing constants, types and helpers for the video path
package vga_pkg;

  // Raster counters are fixed-width; any timing set must fit inside them.
  localparam int CNT_W     = 10;
  localparam int CNT_LIMIT = 1 << CNT_W;

  // Output colour is {R1,R0,G1,G0,B1,B0}.
  localparam int RGB_W = 6;

  // Default 640x480@60 timing.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Asserted sync level encoding.
  localparam int SYNC_ACTIVE_LOW  = 0;
  localparam int SYNC_ACTIVE_HIGH = 1;

  // Deepest overlay pipeline the delay line is allowed to match.
  localparam int MAX_PIPE_DELAY = 3;

  // Timing flags carried through the delay line; all asserted-high.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } sync_bits_t;

  // Total clocks per line or lines per frame.
  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - fixed-depth shift register that delay-matches timing flags
module sync_delay_line
  import vga_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  if (DEPTH < 0 || DEPTH > MAX_PIPE_DELAY) begin : g_bad_depth
    $error("sync_delay_line: DEPTH must be within 0..3");
  end

  if (DEPTH == 0) begin : g_wire
    // No overlay latency to match: pass straight through.
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst_n;
    assign data_out    = data_in;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift flags one stage per clock; reset flushes to inactive/not-asserted.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage[i] <= '0;
        end
      end else begin
        stage[0] <= data_in;
        for (int i = 1; i < DEPTH; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign data_out = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_mixer.sv
// rtl/vga_timing_mixer.sv - raster timing generator and overlay/background colour mixer
module vga_timing_mixer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int SYNC_POL   = SYNC_ACTIVE_LOW,
  parameter int PIPE_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_active,
  output logic             line_start,
  output logic             frame_start,
  input  logic [RGB_W-1:0] overlay_rgb,
  input  logic             overlay_active,
  input  logic [RGB_W-1:0] bg_rgb,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb,
  output logic [7:0]       frame_count
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_bad_totals
    $error("vga_timing_mixer: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
  end

  if (PIPE_DELAY < 0 || PIPE_DELAY > MAX_PIPE_DELAY) begin : g_bad_delay
    $error("vga_timing_mixer: PIPE_DELAY must be within 0..3");
  end

  // Thresholds are one bit wider than the counters so a sync window ending
  // exactly at 1024 still compares correctly.
  localparam int CMP_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
  localparam logic [CMP_W-1:0] H_ACT    = CMP_W'(H_ACTIVE);
  localparam logic [CMP_W-1:0] V_ACT    = CMP_W'(V_ACTIVE);
  localparam logic [CMP_W-1:0] HS_START = CMP_W'(H_ACTIVE + H_FP);
  localparam logic [CMP_W-1:0] HS_END   = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CMP_W-1:0] VS_START = CMP_W'(V_ACTIVE + V_FP);
  localparam logic [CMP_W-1:0] VS_END   = CMP_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CMP_W-1:0] h_ext;
  logic [CMP_W-1:0] v_ext;
  sync_bits_t       raw_bits;
  sync_bits_t       dly_bits;
  logic [RGB_W-1:0] mix_rgb;

  // Free-running raster counters; frame_count ticks on the last pixel of a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_count <= '0;
    end else if (h_cnt == H_MAX) begin
      h_cnt <= '0;
      if (v_cnt == V_MAX) begin
        v_cnt       <= '0;
        frame_count <= frame_count + 8'd1;
      end else begin
        v_cnt <= v_cnt + 1'b1;
      end
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Coordinate outputs and raw (undelayed, asserted-high) timing flags.
  always_comb begin
    h_ext          = {1'b0, h_cnt};
    v_ext          = {1'b0, v_cnt};
    x              = h_cnt;
    y              = v_cnt;
    frame_active   = (h_ext < H_ACT) && (v_ext < V_ACT);
    line_start     = (h_cnt == '0);
    frame_start    = (h_cnt == '0) && (v_cnt == '0);
    raw_bits       = '0;
    raw_bits.active = frame_active;
    raw_bits.hsync = (h_ext >= HS_START) && (h_ext < HS_END);
    raw_bits.vsync = (v_ext >= VS_START) && (v_ext < VS_END);
  end

  sync_delay_line #(
    .DEPTH (PIPE_DELAY),
    .WIDTH ($bits(sync_bits_t))
  ) u_sync_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (raw_bits),
    .data_out (dly_bits)
  );

  // Overlay wins over background inside the active area; black elsewhere.
  always_comb begin
    mix_rgb = '0;
    if (dly_bits.active) begin
      mix_rgb = overlay_active ? overlay_rgb : bg_rgb;
    end
  end

  // Output register keeps colour and syncs leaving on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb   <= '0;
      hsync <= SYNC_OFF;
      vsync <= SYNC_OFF;
    end else begin
      rgb   <= mix_rgb;
      hsync <= dly_bits.hsync ? SYNC_ON : SYNC_OFF;
      vsync <= dly_bits.vsync ? SYNC_ON : SYNC_OFF;
    end
  end

endmodule

// File: tb/tb_vga_timing_mixer.sv
// tb/tb_vga_timing_mixer.sv - randomized bench for vga_timing_mixer at three pipeline depths
module tb_vga_timing_mixer;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 5, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] overlay_rgb = '0;
  logic       overlay_active = 1'b0;
  logic [5:0] bg_rgb = '0;

  logic [9:0] x_o [NI];
  logic [9:0] y_o [NI];
  logic       fa_o [NI];
  logic       ls_o [NI];
  logic       fs_o [NI];
  logic       hs_o [NI];
  logic       vs_o [NI];
  logic [5:0] rgb_o [NI];
  logic [7:0] fc_o [NI];

  int errors = 0;
  int checks = 0;
  int t = 0;
  int mode = 0;
  logic [5:0] ov_q [$];
  logic       oa_q [$];
  logic [5:0] bg_q [$];

  always #5 clk = ~clk;

  vga_timing_mixer #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(0), .PIPE_DELAY(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .x(x_o[0]), .y(y_o[0]), .frame_active(fa_o[0]),
    .line_start(ls_o[0]), .frame_start(fs_o[0]), .overlay_rgb(overlay_rgb),
    .overlay_active(overlay_active), .bg_rgb(bg_rgb), .hsync(hs_o[0]), .vsync(vs_o[0]),
    .rgb(rgb_o[0]), .frame_count(fc_o[0]));

  vga_timing_mixer #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(0), .PIPE_DELAY(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .x(x_o[1]), .y(y_o[1]), .frame_active(fa_o[1]),
    .line_start(ls_o[1]), .frame_start(fs_o[1]), .overlay_rgb(overlay_rgb),
    .overlay_active(overlay_active), .bg_rgb(bg_rgb), .hsync(hs_o[1]), .vsync(vs_o[1]),
    .rgb(rgb_o[1]), .frame_count(fc_o[1]));

  vga_timing_mixer #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(0), .PIPE_DELAY(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .x(x_o[2]), .y(y_o[2]), .frame_active(fa_o[2]),
    .line_start(ls_o[2]), .frame_start(fs_o[2]), .overlay_rgb(overlay_rgb),
    .overlay_active(overlay_active), .bg_rgb(bg_rgb), .hsync(hs_o[2]), .vsync(vs_o[2]),
    .rgb(rgb_o[2]), .frame_count(fc_o[2]));

  // Reference raster: position is just elapsed clocks since reset release.
  function automatic int mh(input int c);
    return c % HT;
  endfunction

  function automatic int mv(input int c);
    return (c / HT) % VT;
  endfunction

  function automatic bit m_active(input int c);
    return (c >= 0) && (mh(c) < HA) && (mv(c) < VA);
  endfunction

  function automatic bit m_hsync(input int c);
    return (c >= 0) && (mh(c) >= HA + HFP) && (mh(c) < HA + HFP + HS);
  endfunction

  function automatic bit m_vsync(input int c);
    return (c >= 0) && (mv(c) >= VA + VFP) && (mv(c) < VA + VFP + VS);
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d t=%0d observed=%0h expected=%0h", tag, k, t, obs, exp);
    end
  endtask

  // Outputs at clock t reflect the raster PIPE_DELAY+1 clocks earlier and the
  // overlay inputs presented one clock earlier.
  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      int d;
      int src;
      logic [5:0] e_rgb;
      d = (k == 2) ? 3 : k;
      src = t - 1 - d;
      e_rgb = '0;
      if (m_active(src)) e_rgb = oa_q[t-1] ? ov_q[t-1] : bg_q[t-1];
      chk("x", k, 32'(x_o[k]), 32'(mh(t)));
      chk("y", k, 32'(y_o[k]), 32'(mv(t)));
      chk("frame_active", k, 32'(fa_o[k]), 32'(m_active(t)));
      chk("line_start", k, 32'(ls_o[k]), 32'(mh(t) == 0));
      chk("frame_start", k, 32'(fs_o[k]), 32'(mh(t) == 0 && mv(t) == 0));
      chk("hsync", k, 32'(hs_o[k]), 32'(!m_hsync(src)));
      chk("vsync", k, 32'(vs_o[k]), 32'(!m_vsync(src)));
      chk("rgb", k, 32'(rgb_o[k]), 32'(e_rgb));
      chk("frame_count", k, 32'(fc_o[k]), 32'((t / FRAME) % 256));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      check_all();
      if (mode == 1) begin
        bg_rgb = 6'b000011;
        overlay_rgb = 6'b111111;
        overlay_active = 1'($urandom_range(0, 1));
      end else begin
        bg_rgb = 6'($urandom);
        overlay_rgb = 6'($urandom);
        overlay_active = 1'($urandom_range(0, 1));
      end
      ov_q.push_back(overlay_rgb);
      oa_q.push_back(overlay_active);
      bg_q.push_back(bg_rgb);
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_x", k, 32'(x_o[k]), 32'd0);
      chk("rst_y", k, 32'(y_o[k]), 32'd0);
      chk("rst_rgb", k, 32'(rgb_o[k]), 32'd0);
      chk("rst_hsync", k, 32'(hs_o[k]), 32'd1);
      chk("rst_vsync", k, 32'(vs_o[k]), 32'd1);
      chk("rst_frame_count", k, 32'(fc_o[k]), 32'd0);
    end
    rst_n = 1'b1;
    t = 0;
    ov_q.delete();
    oa_q.delete();
    bg_q.delete();
  endtask

  initial begin
    do_reset(3);
    mode = 1;
    run(FRAME + 40);
    mode = 0;
    run(2 * FRAME);
    run(FRAME - (t % FRAME) + 3 * HT + 5);
    do_reset(1);
    mode = 1;
    run(FRAME);
    mode = 0;
    run(256 * FRAME + 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
